sync_bus_filt: RTL

- Parametrised successor of the single-bit two-flop synchroniser.
- Brings a WIDTH-bit bundle of independent asynchronous level signals into the clk domain.
- Each bit has a configurable-depth flop chain, an optional consecutive-cycle stability filter (deglitcher) and registered edge pulses.
- Sits at every async input boundary: pins, status bits from other domains, and quasi-static configuration.
- Not for multi-bit coherent buses; each bit is synchronised independently.

---
 rtl/sync_pkg.sv | 14 +
 rtl/sync_chan.sv | 111 +++++++++++
 rtl/sync_bus_filt.sv | 41 ++++
 3 files changed

// File: rtl/sync_pkg.sv
// Shared constants and helpers for the multi-bit level synchroniser.
// Latency: n/a (no logic).
// Backpressure: n/a (no handshake).
package sync_pkg;

    // Fewer than two flops gives no metastability settling time.
    localparam int SYNC_STAGES_MIN = 2;

    // Counter width for a filter threshold; counts 0..filt-1, never narrower than 1 bit.
    function automatic int sync_cnt_w(input int filt);
        return (filt <= 2) ? 1 : $clog2(filt);
    endfunction

endpackage

// File: rtl/sync_chan.sv
// One channel: flop-chain synchroniser, optional stability filter, optional edge pulses (SYNC_EDGE_DET_EN).
// Latency: STAGES edges to out, plus FILT_CYCLES edges when the filter is enabled.
// Backpressure: none; level inputs are sampled every clk edge.
module sync_chan
    import sync_pkg::*;
#(
    parameter int   STAGES      = 2,
    parameter int   FILT_CYCLES = 0,
    parameter logic RST_VAL_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic out,
    output logic pending
`ifdef SYNC_EDGE_DET_EN
    ,
    output logic rise,
    output logic fall
`endif
);

    if (STAGES < SYNC_STAGES_MIN) begin : g_bad_stages
        $error("sync_chan: STAGES must be at least %0d", SYNC_STAGES_MIN);
    end

    logic [STAGES-1:0] chain;
    logic              s;

    assign s = chain[STAGES-1];

    // Synchroniser chain: in enters at bit 0, s leaves at the top.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= {STAGES{RST_VAL_BIT}};
        end else begin
            chain <= {chain[STAGES-2:0], in};
        end
    end

    if (FILT_CYCLES == 0) begin : g_bypass
        assign out     = s;
        assign pending = 1'b0;

`ifdef SYNC_EDGE_DET_EN
        // s will take chain[STAGES-2] on this edge, so the pulse lands with the new out value.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rise <= 1'b0;
                fall <= 1'b0;
            end else begin
                rise <= ~s &  chain[STAGES-2];
                fall <=  s & ~chain[STAGES-2];
            end
        end
`endif
    end else begin : g_filt
        localparam int              CW      = sync_cnt_w(FILT_CYCLES);
        localparam logic [CW-1:0]   CNT_MAX = CW'(FILT_CYCLES - 1);

        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_nxt;
        logic          out_q;
        logic          out_nxt;
        logic          pend_q;

        // Filter decision: a differing s must persist FILT_CYCLES edges; any return to out restarts.
        always_comb begin
            cnt_nxt = cnt;
            out_nxt = out_q;
            if (s == out_q) begin
                cnt_nxt = '0;
            end else if (cnt == CNT_MAX) begin
                out_nxt = s;
                cnt_nxt = '0;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end

        // Filter state; pending reflects s against the freshly updated out.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                out_q  <= RST_VAL_BIT;
                cnt    <= '0;
                pend_q <= 1'b0;
            end else begin
                out_q  <= out_nxt;
                cnt    <= cnt_nxt;
                pend_q <= (s != out_nxt);
            end
        end

        assign out     = out_q;
        assign pending = pend_q;

`ifdef SYNC_EDGE_DET_EN
        // Pulse on the same edge out changes, derived from the next-state value.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rise <= 1'b0;
                fall <= 1'b0;
            end else begin
                rise <= ~out_q &  out_nxt;
                fall <=  out_q & ~out_nxt;
            end
        end
`endif
    end

endmodule

// File: rtl/sync_bus_filt.sv
// WIDTH independent async level inputs synchronised, deglitched and edge-detected (edges with SYNC_EDGE_DET_EN).
// Latency: STAGES edges, plus FILT_CYCLES edges when FILT_CYCLES > 0.
// Backpressure: none; not for coherent multi-bit buses, every bit is handled on its own.
module sync_bus_filt #(
    parameter int               WIDTH       = 1,
    parameter int               STAGES      = 2,
    parameter int               FILT_CYCLES = 0,
    parameter logic [WIDTH-1:0] RST_VAL     = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] pending
`ifdef SYNC_EDGE_DET_EN
    ,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
`endif
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        sync_chan #(
            .STAGES      (STAGES),
            .FILT_CYCLES (FILT_CYCLES),
            .RST_VAL_BIT (RST_VAL[i])
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .in      (in[i]),
            .out     (out[i]),
            .pending (pending[i])
`ifdef SYNC_EDGE_DET_EN
            ,
            .rise    (rise[i]),
            .fall    (fall[i])
`endif
        );
    end

endmodule
